// File: rtl/mau_pkg.sv
// Shared size codes and FSM state encoding for the memory access unit.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lane_align.sv
// Combinational lane steering: store-side byte enables and replicated data,
// alignment check, and load-side lane extraction with sign/zero extension.
module lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_lane,
    input  logic        rd_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = lane[0];
            end
            // size 11 behaves exactly like a word access
            default: begin
                be       = 4'b1111;
                misalign = (lane != 2'b00);
            end
        endcase
    end

    always_comb begin
        case (rd_lane)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = rd_lane[1] ? rdata[31:16] : rdata[15:0];
        case (rd_size)
            SZ_BYTE: rdata_ext = rd_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: rdata_ext = rd_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: IDLE captures an aligned request, WAIT drives a
// registered bus cycle until ack or timeout, DONE releases the CPU stall.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        timeout_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  fsm_state
);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [1:0]  size_q, lane_q;
    logic        uns_q;
    logic [31:0] rdata_q;
    logic        to_q;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, rext_c;
    logic        mis_c;
    logic        req_any, start, timed_out;

    assign req_any   = req_read | req_write;
    assign start     = (state == IDLE) && req_any && !mis_c;
    assign timed_out = (cnt == 16'(TIMEOUT - 1));
    assign fsm_state = state;

    lane_align u_align (
        .size        (req_size),
        .lane        (req_addr[1:0]),
        .wdata       (req_wdata),
        .be          (be_c),
        .wdata_rep   (wdata_c),
        .misalign    (mis_c),
        .rd_size     (size_q),
        .rd_lane     (lane_q),
        .rd_unsigned (uns_q),
        .rdata       (mem_rdata),
        .rdata_ext   (rext_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WAIT;
            WAIT:    if (mem_ack || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Misaligned requests are answered in the same IDLE cycle with no bus cycle.
    always_comb begin
        stall       = start || (state == WAIT);
        misalign    = (state == IDLE) && req_any && mis_c;
        rdata       = misalign ? 32'h0 : rdata_q;
        timeout_err = to_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            size_q    <= '0;
            lane_q    <= '0;
            uns_q     <= 1'b0;
            rdata_q   <= '0;
            to_q      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            to_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_write;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= be_c;
                        mem_wdata <= wdata_c;
                        size_q    <= req_size;
                        lane_q    <= req_addr[1:0];
                        uns_q     <= req_unsigned;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= rext_c;
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        rdata_q <= '0;
                        to_q    <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table of single transfers plus reset and
// random byte-load sequences, with load results checked through a queue.
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int TO    = 4;
    localparam int NEVER = 99;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          ack;
        logic        mis;
        logic        we;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        stall, misalign, timeout_err, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [1:0]  fsm_state;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[13];

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall), .misalign(misalign), .timeout_err(timeout_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mrd, input int ack, input logic mis,
                                input logic [3:0] be, input logic [31:0] maddr,
                                input logic [31:0] mwdata, input logic [31:0] rd_exp);
        vec_t v;
        v.wr = wr; v.rd = rd; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.mrd = mrd; v.ack = ack; v.mis = mis; v.we = wr; v.be = be; v.maddr = maddr;
        v.mwdata = mwdata; v.rdata = rd_exp;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int  waitc, stall_n, exp_stall, exp_req;
        bit  done;
        @(negedge clock);
        req_write = v.wr; req_read = v.rd; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.mrd;
        #1;
        if (v.mis) begin
            check({tag, "_misalign"}, 32'(misalign), 32'd1);
            check({tag, "_mis_stall"}, 32'(stall), 32'd0);
            check({tag, "_mis_rdata"}, rdata, 32'h0);
            check({tag, "_mis_req"}, 32'(mem_req), 32'd0);
            @(negedge clock); #1;
            check({tag, "_mis_req2"}, 32'(mem_req), 32'd0);
            check({tag, "_mis_state"}, 32'(fsm_state), 32'(IDLE));
            req_read = 1'b0; req_write = 1'b0; #1;
            check({tag, "_mis_clear"}, 32'(misalign), 32'd0);
            return;
        end
        exp_q.push_back(v.rdata);
        check({tag, "_stall_first"}, 32'(stall), 32'd1);
        stall_n = 1; waitc = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            #1;
            if (!stall) done = 1;
            else begin
                stall_n++;
                if (mem_req) begin
                    check({tag, "_we"}, 32'(mem_we), 32'(v.we));
                    check({tag, "_addr"}, mem_addr, v.maddr);
                    check({tag, "_be"}, 32'(mem_be), 32'(v.be));
                    check({tag, "_wdata"}, mem_wdata, v.mwdata);
                    if (waitc == v.ack) mem_ack = 1'b1;
                    waitc++;
                end
            end
        end
        if (!done) check({tag, "_stall_bound"}, 32'd0, 32'd1);
        exp_stall = (v.ack >= TO) ? TO + 1 : v.ack + 2;
        exp_req   = (v.ack >= TO) ? TO : v.ack + 1;
        check({tag, "_stall_len"}, 32'(stall_n), 32'(exp_stall));
        check({tag, "_req_len"}, 32'(waitc), 32'(exp_req));
        check({tag, "_timeout"}, 32'(timeout_err), (v.ack >= TO) ? 32'd1 : 32'd0);
        check({tag, "_state_done"}, 32'(fsm_state), 32'(DONE));
        check({tag, "_req_low"}, 32'(mem_req), 32'd0);
        if (exp_q.size() > 0) check({tag, "_rdata"}, rdata, exp_q.pop_front());
        else check({tag, "_queue_empty"}, 32'd0, 32'd1);
        req_read = 1'b0; req_write = 1'b0;
        @(negedge clock); #1;
        check({tag, "_to_pulse_end"}, 32'(timeout_err), 32'd0);
        check({tag, "_state_idle"}, 32'(fsm_state), 32'(IDLE));
        check({tag, "_rdata_held"}, rdata, v.rdata);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, SZ_WORD, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(0, 1, SZ_BYTE, 0, 32'h203, 32'h0, 32'h80112233, 1, 0, 4'b1000, 32'h200, 32'h0, 32'hFFFFFF80);
        vecs[2]  = mk(0, 1, SZ_BYTE, 1, 32'h203, 32'h0, 32'h80112233, 2, 0, 4'b1000, 32'h200, 32'h0, 32'h00000080);
        vecs[3]  = mk(1, 0, SZ_HALF, 0, 32'h102, 32'h0000ABCD, 32'h0, 0, 0, 4'b1100, 32'h100, 32'hABCDABCD, 32'h0);
        vecs[4]  = mk(0, 1, SZ_HALF, 0, 32'h101, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[5]  = mk(0, 1, SZ_WORD, 0, 32'h300, 32'h0, 32'h55AA55AA, NEVER, 0, 4'b1111, 32'h300, 32'h0, 32'h0);
        vecs[6]  = mk(1, 1, SZ_BYTE, 0, 32'h10, 32'h0000005A, 32'h0, 0, 0, 4'b0001, 32'h10, 32'h5A5A5A5A, 32'h0);
        vecs[7]  = mk(0, 1, SZ_HALF, 0, 32'h202, 32'h0, 32'h80112233, 0, 0, 4'b1100, 32'h200, 32'h0, 32'hFFFF8011);
        vecs[8]  = mk(0, 1, SZ_HALF, 1, 32'h200, 32'h0, 32'h1234F00D, 3, 0, 4'b0011, 32'h200, 32'h0, 32'h0000F00D);
        vecs[9]  = mk(0, 1, SZ_BYTE, 0, 32'h41, 32'h0, 32'h11227F44, 0, 0, 4'b0010, 32'h40, 32'h0, 32'h0000007F);
        vecs[10] = mk(0, 1, SZ_WORD, 0, 32'h102, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[11] = mk(0, 1, 2'b11, 0, 32'h40, 32'h0, 32'hCAFEF00D, 1, 0, 4'b1111, 32'h40, 32'h0, 32'hCAFEF00D);
        vecs[12] = mk(1, 0, SZ_BYTE, 0, 32'h42, 32'h123456AB, 32'h0, 0, 0, 4'b0100, 32'h40, 32'hABABABAB, 32'h0);

        // reset state
        repeat (2) @(negedge clock);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // random unsigned byte loads against an independent lane model
        for (int r = 0; r < 6; r++) begin
            int          lane;
            logic [31:0] mrd, a, shifted;
            lane    = $urandom_range(0, 3);
            mrd     = $urandom;
            a       = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'(lane);
            shifted = mrd >> (8 * lane);
            run_vec(mk(0, 1, SZ_BYTE, 1, a, 32'h0, mrd, $urandom_range(0, 2), 0,
                       4'(1 << lane), {a[31:2], 2'b00}, 32'h0, {24'h0, shifted[7:0]}),
                    $sformatf("rnd%0d", r));
        end

        // reset during WAIT, then a stray ack
        @(negedge clock);
        req_read = 1'b1; req_size = SZ_WORD; req_addr = 32'h500; req_unsigned = 1'b0;
        for (int c = 0; c < 4 && !mem_req; c++) begin
            @(negedge clock); #1;
        end
        check("mid_req_seen", 32'(mem_req), 32'd1);
        reset = 1'b0; req_read = 1'b0;
        #1;
        check("mid_req_drop", 32'(mem_req), 32'd0);
        check("mid_state", 32'(fsm_state), 32'(IDLE));
        check("mid_stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset = 1'b1; mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0; #1;
        check("late_ack_state", 32'(fsm_state), 32'(IDLE));
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_rdata", rdata, 32'h0);
        check("late_ack_timeout", 32'(timeout_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
